// File: rtl/reg_file_pkg.sv
// Shared definitions for the integer register file: default geometry,
// the hard-wired zero register address and the clear-sequencer states.
package reg_file_pkg;

  localparam int RFW_DEF   = 5;
  localparam int DW_DEF    = 32;
  localparam int REG0_ADDR = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/reg_file_if.sv
// Operand-read / write-back bus of the register file.
// master = pipeline side, slave = register file.
interface reg_file_if
  import reg_file_pkg::*;
#(
  parameter int RFW = RFW_DEF,
  parameter int DW  = DW_DEF
) ();

  logic           rf_we;
  logic [RFW-1:0] rd;
  logic [DW-1:0]  rd_data;
  logic           re;
  logic [RFW-1:0] rs1;
  logic [RFW-1:0] rs2;
  logic [DW-1:0]  rs1_data;
  logic [DW-1:0]  rs2_data;
  logic           rf_ready;

  modport master (
    output rf_we, rd, rd_data, re, rs1, rs2,
    input  rs1_data, rs2_data, rf_ready
  );

  modport slave (
    input  rf_we, rd, rd_data, re, rs1, rs2,
    output rs1_data, rs2_data, rf_ready
  );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: walks every register-file entry once,
// one per cycle, then holds READY until the next reset.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int RFW = RFW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  output logic           clr_we,
  output logic [RFW-1:0] clr_addr,
  output logic           rf_ready
);

  rf_state_e      state, state_nxt;
  logic [RFW-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_we    = 1'b0;
    rf_ready  = 1'b0;
    case (state)
      CLEAR: begin
        clr_we  = 1'b1;
        cnt_nxt = cnt + RFW'(1);
        // The last entry is written on the same edge that enters READY.
        if (&cnt) state_nxt = READY;
      end
      READY: rf_ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/reg_file.sv
// Two-read / one-write integer register file with x0 hard-wired to zero.
// Define RF_BYPASS_EN for write-first same-cycle forwarding (default: read-first).
module reg_file
  import reg_file_pkg::*;
#(
  parameter int RFW = RFW_DEF,
  parameter int DW  = DW_DEF
) (
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  localparam logic [RFW-1:0] X0 = RFW'(REG0_ADDR);

  logic [DW-1:0]  mem [2**RFW];
  logic           clr_we;
  logic [RFW-1:0] clr_addr;
  logic           ready;
  logic           ext_we;
  logic           mem_we;
  logic [RFW-1:0] mem_waddr;
  logic [DW-1:0]  mem_wdata;
  logic [DW-1:0]  rs1_nxt;
  logic [DW-1:0]  rs2_nxt;

  rf_clear_seq #(.RFW(RFW)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .rf_ready (ready)
  );

  // External writes are dropped (not queued) while the sequencer owns the port.
  assign ext_we    = ready & bus.rf_we & (bus.rd != X0);
  assign mem_we    = clr_we | ext_we;
  assign mem_waddr = clr_we ? clr_addr : bus.rd;
  assign mem_wdata = clr_we ? '0 : bus.rd_data;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_comb begin
    rs1_nxt = (bus.rs1 == X0) ? '0 : mem[bus.rs1];
    rs2_nxt = (bus.rs2 == X0) ? '0 : mem[bus.rs2];
`ifdef RF_BYPASS_EN
    if (ext_we && (bus.rs1 == bus.rd)) rs1_nxt = bus.rd_data;
    if (ext_we && (bus.rs2 == bus.rd)) rs2_nxt = bus.rd_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rs1_data <= '0;
      bus.rs2_data <= '0;
    end else if (ready && bus.re) begin
      bus.rs1_data <= rs1_nxt;
      bus.rs2_data <= rs2_nxt;
    end
  end

  assign bus.rf_ready = ready;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file; expectations follow RF_BYPASS_EN when it is defined.
module tb_reg_file;

  localparam int RFW = 5;
  localparam int DW  = 32;
  localparam int N   = 2**RFW;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_file_if #(.RFW(RFW), .DW(DW)) bus ();

  reg_file #(.RFW(RFW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string         tag;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
    logic          rdy;
  } exp_t;

  exp_t           sb[$];
  logic [DW-1:0]  m_mem [N];
  logic           m_ready = 1'b0;
  logic [RFW-1:0] m_cnt   = '0;
  logic [DW-1:0]  m_o1    = '0;
  logic [DW-1:0]  m_o2    = '0;
  int             passes  = 0;
  int             total   = 0;

  function automatic logic [DW-1:0] m_read(input int a, input bit we, input int wa,
                                           input logic [DW-1:0] wd);
    if (a == 0) return '0;
    if (BYP && we && wa != 0 && wa == a) return wd;
    return m_mem[a];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed %h expected %h", tag, obs, exp);
  endtask

  // One clock: drive inputs, push the model's expectation, step, pop and compare.
  task automatic cyc(input string tag, input bit r, input bit we, input int wa,
                     input logic [DW-1:0] wd, input bit re_i, input int a1, input int a2);
    exp_t e;
    logic [DW-1:0] n1, n2;
    logic nrdy;
    logic [RFW-1:0] ncnt;
    rst         = r;
    bus.rf_we   = we;
    bus.rd      = wa[RFW-1:0];
    bus.rd_data = wd;
    bus.re      = re_i;
    bus.rs1     = a1[RFW-1:0];
    bus.rs2     = a2[RFW-1:0];
    n1 = m_o1; n2 = m_o2; nrdy = m_ready; ncnt = m_cnt;
    if (r) begin
      n1 = '0; n2 = '0; nrdy = 1'b0; ncnt = '0;
    end else if (!m_ready) begin
      m_mem[m_cnt] = '0;
      nrdy = (m_cnt == RFW'(N-1));
      ncnt = m_cnt + RFW'(1);
    end else begin
      if (re_i) begin
        n1 = m_read(a1, we, wa, wd);
        n2 = m_read(a2, we, wa, wd);
      end
      if (we && wa != 0) m_mem[wa] = wd;
    end
    e.tag = tag; e.d1 = n1; e.d2 = n2; e.rdy = nrdy;
    sb.push_back(e);
    m_o1 = n1; m_o2 = n2; m_ready = nrdy; m_cnt = ncnt;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".rs1_data"}, bus.rs1_data, e.d1);
    chk({e.tag, ".rs2_data"}, bus.rs2_data, e.d2);
    chk({e.tag, ".rf_ready"}, {{(DW-1){1'b0}}, bus.rf_ready}, {{(DW-1){1'b0}}, e.rdy});
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wa, a1, a2;
    bit we, re_i;
    logic [DW-1:0] wd;

    // Reset and the 32-cycle clear; rf_ready is compared on every cycle.
    cyc("reset", 1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    idle("clear", N);
    for (int a = 1; a < N; a++) cyc("zero", 1'b0, 1'b0, 0, '0, 1'b1, a, (a + 1) % N);

    // Basic write / read and x0 protection
    cyc("wr5", 1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 0);
    cyc("rd5", 1'b0, 1'b0, 0, '0, 1'b1, 5, 0);
    cyc("hold5", 1'b0, 1'b0, 0, '0, 1'b0, 0, 0);
    cyc("wr0", 1'b0, 1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 0);
    cyc("rd0", 1'b0, 1'b0, 0, '0, 1'b1, 0, 0);
    cyc("same", 1'b0, 1'b0, 0, '0, 1'b1, 5, 5);

    // Same-cycle write/read hazard on x7
    cyc("wr7", 1'b0, 1'b1, 7, 32'h11, 1'b0, 0, 0);
    cyc("haz7", 1'b0, 1'b1, 7, 32'h22, 1'b1, 7, 7);
    cyc("rd7", 1'b0, 1'b0, 0, '0, 1'b1, 7, 7);
    cyc("haz0", 1'b0, 1'b1, 0, 32'h33, 1'b1, 0, 7);

    // Stall hold
    cyc("wr3", 1'b0, 1'b1, 3, 32'hAAAA, 1'b0, 0, 0);
    cyc("rd3", 1'b0, 1'b0, 0, '0, 1'b1, 3, 3);
    cyc("stall1", 1'b0, 1'b1, 4, 32'h1, 1'b0, 5, 4);
    cyc("stall2", 1'b0, 1'b1, 3, 32'hBBBB, 1'b0, 4, 3);
    cyc("resume", 1'b0, 1'b0, 0, '0, 1'b1, 5, 4);
    cyc("rd3b", 1'b0, 1'b0, 0, '0, 1'b1, 3, 0);

    // Random traffic, biased toward read-after-write on the same address
    for (int i = 0; i < 60; i++) begin
      we   = ($urandom_range(0, 1) == 1);
      wa   = $urandom_range(0, N - 1);
      wd   = $urandom;
      re_i = ($urandom_range(0, 3) != 0);
      a1   = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, N - 1);
      a2   = ($urandom_range(0, 2) == 0) ? wa : $urandom_range(0, N - 1);
      cyc("rand", 1'b0, we, wa, wd, re_i, a1, a2);
    end

    // Reset in READY, then again mid-clear; writes during clear must be dropped.
    cyc("wr9", 1'b0, 1'b1, 9, 32'h55, 1'b0, 0, 0);
    cyc("rd9", 1'b0, 1'b0, 0, '0, 1'b1, 9, 0);
    cyc("rst2", 1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) cyc("clr_a", 1'b0, 1'b1, 9, 32'h1234, 1'b1, 9, 9);
    cyc("rst3", 1'b1, 1'b0, 0, '0, 1'b0, 0, 0);
    for (int i = 0; i < N; i++) cyc("clr_b", 1'b0, 1'b1, (i % 2) ? 9 : 12, 32'h5678, 1'b1, 9, 12);
    cyc("post9", 1'b0, 1'b0, 0, '0, 1'b1, 9, 12);
    cyc("post5", 1'b0, 1'b0, 0, '0, 1'b1, 5, 7);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
